// File: rtl/mult_sched_pkg.sv
// Shared constants for the shared-multiplier scheduler: FSM state codes and
// datapath adder-select encodings.
package mult_sched_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [2:0] SEL_ADD  = 3'b000;
  localparam logic [2:0] SEL_PASS = 3'b001;

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from i_ptr, wrapping at NREQ,
// and returns the first active request as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_enable,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end
      if (i_enable && !w_found && i_req[w_pos]) begin
        o_gnt[w_pos] = 1'b1;
        o_idx        = IDX_W'(w_pos);
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one sequential shift-add multiplier datapath
// between NREQ requesters; sequences the datapath and returns the product.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [2*WIDTH-1:0]    result,
  output logic                  busy,
  output logic [WIDTH-1:0]      dp_a_op,
  output logic [WIDTH-1:0]      dp_b_op,
  output logic                  dp_zero,
  output logic                  dp_lda,
  output logic                  dp_ldb,
  output logic                  dp_ldp,
  output logic                  dp_shen,
  output logic [2:0]            dp_sel,
  input  logic                  dp_a0,
  input  logic [2*WIDTH-1:0]    dp_prod
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_result;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic               r_busy;

  logic [NREQ-1:0]    w_arb_gnt;
  logic [IDX_W-1:0]   w_arb_idx;
  logic               w_arb_en;

  assign w_arb_en = (r_state == ST_IDLE);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .i_enable (w_arb_en),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (|req) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_LOAD;
      ST_LOAD:    w_next = ST_RUN;
      ST_RUN:     if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_owner <= w_arb_idx;
            r_gnt   <= w_arb_gnt;
          end
        end
        ST_CLEAR: r_cnt <= '0;
        ST_RUN:   r_cnt <= r_cnt + 1'b1;
        ST_CAPTURE: begin
          r_result <= dp_prod;
          // r_gnt is the owner's one-hot, so it doubles as the done mask
          r_done   <= r_gnt;
        end
        ST_DONE: begin
          r_gnt <= '0;
          r_ptr <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign result  = r_result;
  assign busy    = r_busy;
  assign dp_a_op = a_in[r_owner*WIDTH +: WIDTH];
  assign dp_b_op = b_in[r_owner*WIDTH +: WIDTH];

  always_comb begin
    dp_zero = (r_state == ST_CLEAR);
    dp_lda  = (r_state == ST_LOAD);
    dp_ldb  = (r_state == ST_LOAD);
    dp_ldp  = (r_state == ST_RUN);
    dp_shen = (r_state == ST_RUN);
    dp_sel  = ((r_state == ST_RUN) && dp_a0) ? SEL_ADD : SEL_PASS;
  end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one sequential shift-add multiplier datapath between NREQ requesters.
- Arbitrates requests, muxes the winner's operands onto the datapath, and sequences the datapath controls (zero, load, shift-add) for WIDTH iterations.
- Captures the product and returns it to the owner with a one-cycle done pulse.
- Sits between client blocks and the multiplier datapath; it is the only driver of the datapath control lines.

Parameters:
- NREQ, 2, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH; RUN lasts WIDTH cycles.
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester job request, level
- a_in  in  NREQ*WIDTH  multiplicand per requester, slice i = requester i
- b_in  in  NREQ*WIDTH  multiplier per requester, slice i
- gnt  out  NREQ  one-hot owner indication, held for the whole job
- done  out  NREQ  one-cycle completion pulse to the owner
- result  out  2*WIDTH  registered product of the last job
- busy  out  1  high whenever state != IDLE
- dp_a_op  out  WIDTH  owner's a operand to the datapath
- dp_b_op  out  WIDTH  owner's b operand to the datapath
- dp_zero, dp_lda, dp_ldb, dp_ldp, dp_shen  out  1 each  datapath controls
- dp_sel  out  3  adder select: 3'b000 = add, 3'b001 = pass
- dp_a0  in  1  current LSB of datapath multiplier register
- dp_prod  in  2*WIDTH  datapath product register

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr pointer = 0, owner = 0, counter = 0, result = 0.
  - gnt, done, busy and all dp_* controls = 0.
  - dp_sel = 3'b001.
  - Reset mid-job abandons the job; no done pulse is issued.
- States, one per cycle unless noted:
  - IDLE: if any req is high, choose the winner by round robin (scan from ptr upward, wrap at NREQ), register owner, go to CLEAR. Otherwise stay in IDLE.
  - CLEAR: dp_zero = 1; counter = 0; go to LOAD.
  - LOAD: dp_lda = dp_ldb = 1; go to RUN.
  - RUN, WIDTH cycles: dp_ldp = dp_shen = 1; dp_sel = dp_a0 ? 3'b000 : 3'b001; counter increments each cycle; go to CAPTURE when counter == WIDTH-1.
  - CAPTURE: result <= dp_prod at the end of this cycle; go to DONE.
  - DONE: done[owner] = 1; ptr <= (owner+1) mod NREQ; go to IDLE.
- gnt[owner] is 1 from CLEAR through DONE inclusive and 0 in IDLE.
- dp_a_op/dp_b_op always show the owner's slices. The datapath samples them only in LOAD.
- dp_* controls are combinational from state; all other outputs are registered.
- Outside RUN, dp_sel = 3'b001 and dp_ldp = dp_shen = 0.
- Latency: the req-sampling edge is E0; done is high in cycle E0+WIDTH+4 (cycle 12 for WIDTH=8). result is valid from that cycle until the next CAPTURE.
- Gap: at least one IDLE cycle between jobs; throughput is one job per WIDTH+5 cycles.
- req dropped mid-job: the job completes and done still pulses. Abort is not supported.
- req held high after done: re-arbitrated in IDLE with rotated priority, so a continuously requesting client cannot starve the others.
- Simultaneous requests: the lowest index at or above ptr wins (index order, wrapping).
- A requester must hold a_in/b_in stable from its req until LOAD. The scheduler does not latch operands.

Decomposition:
- Package mult_sched_pkg: state enum (IDLE, CLEAR, LOAD, RUN, CAPTURE, DONE); constants SEL_ADD = 3'b000, SEL_PASS = 3'b001.
- Sub-module rr_arbiter: inputs req, ptr, enable; outputs one-hot grant and encoded index. Purely combinational.
- Pointer register, FSM, counter and operand mux live in mult_share_sched.

Test Plan:
- Bench pairs the DUT with a behavioural shift-add datapath model.
- After reset, req0 only with a=13, b=11 → gnt=2'b01 from cycle 1; done[0] in cycle 12; result=16'h008F.
- Reset released, req0 and req1 rise in the same cycle (0x0F×0x03, 0x02×0x05) → requester 0 served first (result 0x002D), then requester 1 after one IDLE cycle (result 0x000A); gnt never 2'b11.
- req0 and req1 held high continuously → grant order 0,1,0,1; each done spaced 13 cycles apart.
- a=255, b=255 → result=16'hFE01. Then a=0, b=0xA5 → result=0. Check the dp_sel sequence during RUN equals the b bits LSB-first (0xA5 → add,pass,add,pass,pass,add,pass,add).
- rst_n pulsed low during RUN cycle 4 → all outputs 0 immediately; no done; next req restarts from CLEAR with ptr=0.
- req1 dropped during RUN → done[1] still pulses with the correct product; busy falls the cycle after DONE.
